// File: rtl/branch_pkg.sv
// Shared types and constants for branch resolution and the 2-bit predictor table.
package branch_pkg;

   localparam int unsigned BHT_ENTRIES_DEF = 16;
   localparam int unsigned CNT_W           = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Condition evaluation from ALU flags; reserved codes resolve not-taken.
   function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                         input logic lt, input logic ltu);
      case (f3)
         F3_BEQ:  return zero;
         F3_BNE:  return !zero;
         F3_BLT:  return lt;
         F3_BGE:  return !lt;
         F3_BLTU: return ltu;
         F3_BGEU: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/satcount2.sv
// Two-bit saturating up/down counter next-state function.
module satcount2
   import branch_pkg::*;
(
   input  ctr_t state,
   input  logic taken,
   output ctr_t next
);

   always_comb begin
      next = state;
      case (state)
         SNT:     next = taken ? WNT : SNT;
         WNT:     next = taken ? WT  : SNT;
         WT:      next = taken ? ST  : WNT;
         ST:      next = taken ? ST  : WT;
         default: next = WNT;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution with a bimodal 2-bit predictor table.
// Optional performance counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve
   import branch_pkg::*;
#(
   parameter int unsigned BHT_ENTRIES = BHT_ENTRIES_DEF,
   parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pcf,
   output logic             predtakenf,
   input  logic [31:0]      pce,
   input  logic             branche,
   input  logic             jumpe,
   input  logic [2:0]       funct3e,
   input  logic             zeroe,
   input  logic             lte,
   input  logic             ltue,
   input  logic             predtakene,
   input  logic             stalle,
   output logic             pcsrce,
   output logic             mispredicte,
   output logic [CNT_W-1:0] brcount,
   output logic [CNT_W-1:0] mispcount
);

   ctr_t             bht [BHT_ENTRIES];
   logic [IDX_W-1:0] fidx;
   logic [IDX_W-1:0] eidx;
   logic [1:0]       fent;
   ctr_t             cur;
   ctr_t             nxt;
   logic             takene;
   logic             isbr;
   logic             upd;
   logic             unused_pc;

   assign fidx      = pcf[IDX_W+1:2];
   assign eidx      = pce[IDX_W+1:2];
   assign unused_pc = ^{pcf[31:IDX_W+2], pcf[1:0], pce[31:IDX_W+2], pce[1:0]};

   // A branch flagged together with a jump behaves purely as a jump.
   assign takene      = branch_taken(funct3e, zeroe, lte, ltue);
   assign isbr        = branche & !jumpe;
   assign upd         = isbr & !stalle;
   assign pcsrce      = jumpe | (isbr & takene);
   assign mispredicte = upd & (takene != predtakene);

   assign fent       = bht[fidx];
   assign predtakenf = fent[1];

   assign cur = bht[eidx];

   satcount2 u_sat (
      .state (cur),
      .taken (takene),
      .next  (nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) bht[i] <= WNT;
      end else if (upd) begin
         bht[eidx] <= nxt;
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         brcount   <= '0;
         mispcount <= '0;
      end else begin
         if (upd && (brcount != '1))           brcount   <= brcount + CNT_W'(1);
         if (mispredicte && (mispcount != '1)) mispcount <= mispcount + CNT_W'(1);
      end
   end
`else
   assign brcount   = '0;
   assign mispcount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a reference predictor model.
`timescale 1ns/1ps
module tb_branch_resolve;

   localparam int BHT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcf, pce;
   logic        branche, jumpe, zeroe, lte, ltue, predtakene, stalle;
   logic [2:0]  funct3e;
   logic        predtakenf, pcsrce, mispredicte;
   logic [31:0] brcount, mispcount;

   int ntests = 0;
   int nfail  = 0;

   int          m_bht [BHT];
   logic [31:0] m_br, m_misp;

   always #5 clk = ~clk;

   branch_resolve dut (
      .clk(clk), .reset(reset), .pcf(pcf), .predtakenf(predtakenf),
      .pce(pce), .branche(branche), .jumpe(jumpe), .funct3e(funct3e),
      .zeroe(zeroe), .lte(lte), .ltue(ltue), .predtakene(predtakene),
      .stalle(stalle), .pcsrce(pcsrce), .mispredicte(mispredicte),
      .brcount(brcount), .mispcount(mispcount)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Branch condition table written directly from the condition-code list.
   function automatic bit ref_taken(input logic [2:0] f, input bit z, input bit lt, input bit ltu);
      bit r;
      r = 1'b0;
      if (f == 3'd0) r = z;
      if (f == 3'd1) r = !z;
      if (f == 3'd4) r = lt;
      if (f == 3'd5) r = !lt;
      if (f == 3'd6) r = ltu;
      if (f == 3'd7) r = !ltu;
      return r;
   endfunction

   function automatic int idx(input logic [31:0] pc);
      return int'((pc / 4) % BHT);
   endfunction

   // Reference model: counters as integers clamped to 0..3, stats as plain sums.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BHT; i++) m_bht[i] <= 1;
         m_br   <= 0;
         m_misp <= 0;
      end else if (branche && !jumpe && !stalle) begin
         if (ref_taken(funct3e, zeroe, lte, ltue))
            m_bht[idx(pce)] <= (m_bht[idx(pce)] < 3) ? m_bht[idx(pce)] + 1 : 3;
         else
            m_bht[idx(pce)] <= (m_bht[idx(pce)] > 0) ? m_bht[idx(pce)] - 1 : 0;
         if (m_br != 32'hFFFF_FFFF) m_br <= m_br + 1;
         if (ref_taken(funct3e, zeroe, lte, ltue) != predtakene && m_misp != 32'hFFFF_FFFF)
            m_misp <= m_misp + 1;
      end
   end

   always @(negedge clk) begin
      bit tk, br;
      tk = ref_taken(funct3e, zeroe, lte, ltue);
      br = branche && !jumpe;
      chk("predtakenf", {31'd0, predtakenf}, {31'd0, m_bht[idx(pcf)] >= 2});
      chk("pcsrce", {31'd0, pcsrce}, {31'd0, jumpe || (br && tk)});
      chk("mispredicte", {31'd0, mispredicte}, {31'd0, br && !stalle && (tk != predtakene)});
`ifdef BRANCH_STATS_EN
      chk("brcount", brcount, m_br);
      chk("mispcount", mispcount, m_misp);
`else
      chk("brcount", brcount, 32'd0);
      chk("mispcount", mispcount, 32'd0);
`endif
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      branche = 0; jumpe = 0; stalle = 0; predtakene = 0;
      zeroe = 0; lte = 0; ltue = 0; funct3e = 3'd0;
   endtask

   task automatic do_reset();
      reset = 1;
      cyc();
      reset = 0;
   endtask

   initial begin
      logic [2:0] codes [8];
      codes = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
      reset = 1; pcf = 0; pce = 0;
      idle();
      repeat (2) cyc();
      reset = 0;

      // Fresh table predicts not-taken; then train entry at 0x40 upward.
      pcf = 32'h40;
      #1 chk("reset_pred", {31'd0, predtakenf}, 32'd0);
      pce = 32'h40; branche = 1; funct3e = 3'd0; zeroe = 1; predtakene = 0;
      #1 chk("beq_pcsrce", {31'd0, pcsrce}, 32'd1);
      chk("beq_misp", {31'd0, mispredicte}, 32'd1);
      cyc();
      chk("after1_pred", {31'd0, predtakenf}, 32'd1);
      cyc(); cyc();
      chk("after3_pred", {31'd0, predtakenf}, 32'd1);
      idle();

      // Condition sweep at 0x3C.
      pce = 32'h3C; branche = 1;
      for (int f = 0; f < 8; f++) begin
         for (int c = 0; c < 8; c++) begin
            funct3e = codes[f];
            {zeroe, lte, ltue} = 3'(c);
            predtakene = c[0];
            cyc();
         end
      end
      funct3e = 3'd2; {zeroe, lte, ltue} = 3'b111;
      #1 chk("f010_pcsrce", {31'd0, pcsrce}, 32'd0);
      funct3e = 3'd5; {zeroe, lte, ltue} = 3'b010;
      #1 chk("bge_lt_pcsrce", {31'd0, pcsrce}, 32'd0);
      funct3e = 3'd6; {zeroe, lte, ltue} = 3'b001;
      #1 chk("bltu_pcsrce", {31'd0, pcsrce}, 32'd1);
      cyc();
      idle();

      // Jump together with branch: redirect, no mispredict, no training.
      pce = 32'h10; pcf = 32'h10; jumpe = 1; branche = 1; predtakene = 1;
      #1 chk("jump_pcsrce", {31'd0, pcsrce}, 32'd1);
      chk("jump_misp", {31'd0, mispredicte}, 32'd0);
      cyc(); cyc();
      chk("jump_noupd", {31'd0, predtakenf}, 32'd0);
      idle();

      // Stalled taken branch must leave the entry alone.
      pce = 32'h08; pcf = 32'h08; branche = 1; zeroe = 1; stalle = 1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("stall_misp", {31'd0, mispredicte}, 32'd0);
         cyc();
      end
      idle();
      #1 chk("stall_noupd", {31'd0, predtakenf}, 32'd0);
      cyc();

      // Same-index lookup and update: old value now, new value after the edge.
      do_reset();
      pcf = 32'h80; pce = 32'h80; branche = 1; zeroe = 1;
      #1 chk("bypass_old", {31'd0, predtakenf}, 32'd0);
      cyc();
      idle();
      chk("bypass_new", {31'd0, predtakenf}, 32'd1);
      cyc();

      // Aliasing between 0x04 and 0x44, then asynchronous reset mid-cycle.
      do_reset();
      pce = 32'h04; pcf = 32'h44; branche = 1; zeroe = 1;
      cyc();
      chk("alias_pred", {31'd0, predtakenf}, 32'd1);
      #2 reset = 1;
      #1 chk("async_reset", {31'd0, predtakenf}, 32'd0);
      cyc();
      reset = 0;
      idle();
      #1 chk("reset_discard", {31'd0, predtakenf}, 32'd0);
      cyc();

      // Ten branches, three mispredicted.
      do_reset();
      pce = 32'h20; branche = 1; zeroe = 1;
      for (int i = 0; i < 10; i++) begin
         predtakene = (i < 3) ? 1'b0 : 1'b1;
         cyc();
      end
      idle();
      #1;
`ifdef BRANCH_STATS_EN
      chk("brcount_10", brcount, 32'd10);
      chk("mispcount_3", mispcount, 32'd3);
`else
      chk("brcount_off", brcount, 32'd0);
      chk("mispcount_off", mispcount, 32'd0);
`endif
      cyc(); cyc();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit predictor entries (power of two, 4..256).
REQ-002 SHALL have parameter IDX_W, default $clog2(BHT_ENTRIES), table index width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pcf  input  32  fetch-stage PC used for prediction lookup.
REQ-006 SHALL have port predtakenf  output  1  fetch-stage taken prediction.
REQ-007 SHALL have port pce  input  32  execute-stage PC of the resolving instruction.
REQ-008 SHALL have port branche  input  1  execute-stage instruction is a conditional branch.
REQ-009 SHALL have port jumpe  input  1  execute-stage instruction is an unconditional jump.
REQ-010 SHALL have port funct3e  input  3  branch condition code.
REQ-011 SHALL have port zeroe, lte, ltue  input  1 each  ALU equal, signed-less-than and unsigned-less-than flags.
REQ-012 SHALL have port predtakene  input  1  prediction carried down the pipe for this instruction.
REQ-013 SHALL have port stalle  input  1  execute stage held; blocks table update.
REQ-014 SHALL have port pcsrce  output  1  redirect PC to the branch/jump target.
REQ-015 SHALL have port mispredicte  output  1  flush request for younger stages.
REQ-016 SHALL have ports brcount, mispcount  output  32 each  performance counters.

Function
REQ-017 SHALL compute takene for funct3e 000 as zeroe, 001 as !zeroe, 100 as lte, 101 as !lte, 110 as ltue and 111 as !ltue; codes 010/011 SHALL give not-taken.
REQ-018 SHALL drive pcsrce = jumpe | (branche & takene), combinationally, with zero latency.
REQ-019 SHALL drive mispredicte = branche & !stalle & (takene != predtakene); jumps never mispredict.
REQ-020 SHALL index the table with pc[IDX_W+1:2] for both lookup and update.
REQ-021 SHALL drive predtakenf = MSB of the entry at pcf's index, combinationally (asynchronous read).
REQ-022 SHALL update an entry on a rising edge only when branche & !stalle: +1 saturating at 11 if taken, -1 saturating at 00 if not taken.
REQ-023 SHALL encode counter states as SNT=00, WNT=01, WT=10, ST=11.
REQ-024 SHALL return the pre-update value when lookup and update hit the same index in the same cycle (no bypass).
REQ-025 SHALL ignore jumpe for table updates; branche & jumpe together SHALL be treated as a jump.

Reset
REQ-026 SHALL set every table entry to WNT immediately on reset assertion, independent of clk.
REQ-027 SHALL clear brcount and mispcount to 0 on reset; combinational outputs follow their inputs during reset.
REQ-028 SHALL discard any update coinciding with reset assertion.

Configuration
REQ-029 SHALL, with BRANCH_STATS_EN defined, increment brcount on each update and mispcount on each mispredicte cycle, both saturating at 32'hFFFF_FFFF.
REQ-030 SHALL, without BRANCH_STATS_EN, tie brcount and mispcount to 0 and infer no counter flops.

Structure
REQ-031 SHALL take the counter-state enum, the funct3 branch-code constants and the BHT_ENTRIES default from package branch_pkg.
REQ-032 SHALL implement the saturating next-state function in sub-module satcount2 (state in, taken in, next state out), instantiated once on the update path.

Verification
REQ-033 SHALL cover: after reset, pcf=0x40 -> predtakenf=0; three taken BEQ (zeroe=1, predtakene=0) at pce=0x40 -> entry 01->10->11->11, predtakenf=1 after first update.
REQ-034 SHALL cover: all six funct3 codes with (zeroe,lte,ltue) sweeping all 8 combinations -> pcsrce per REQ-017; funct3e=010 -> pcsrce=0.
REQ-035 SHALL cover: stalle=1 with branche=1, takene=1 for 5 cycles -> entry unchanged, mispredicte=0.
REQ-036 SHALL cover: pcf and pce both 0x80 with update in the same cycle -> predtakenf shows old value, new value visible next cycle.
REQ-037 SHALL cover: pce=0x04 and pce=0x44 with BHT_ENTRIES=16 -> same entry aliased; reset asserted mid-sequence -> entry reads WNT before the next clk edge.
REQ-038 SHALL cover, with BRANCH_STATS_EN: 10 branches, 3 mispredicted -> brcount=10, mispcount=3; without it both read 0.
